// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART configuration register bank:
//               default bank geometry, word index map and the default
//               reset image (baud divisor in word 0, everything else zero).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default bank geometry
    localparam int UART_CFG_DEPTH = 4;
    localparam int UART_CFG_WIDTH = 32;

    // Word index map
    localparam int CFG_BAUD_DIV = 0;
    localparam int CFG_FRAME    = 1;
    localparam int CFG_PARITY   = 2;
    localparam int CFG_CTRL     = 3;

    // Divisor for 115200 baud from a 50 MHz reference
    localparam logic [UART_CFG_WIDTH-1:0] UART_DEFAULT_BAUD_DIV = 32'd434;

    // Packed reset image for the default geometry: word k at [k*W +: W]
    localparam logic [UART_CFG_DEPTH*UART_CFG_WIDTH-1:0] UART_CFG_RST_VAL =
        {{((UART_CFG_DEPTH-1)*UART_CFG_WIDTH){1'b0}}, UART_DEFAULT_BAUD_DIV};

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_cfg_word.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_word
// Description : One configuration word held as a shadow/active pair.
//               The shadow copy takes byte-enabled host writes; the active
//               copy loads the shadow value (as it stood before this edge)
//               when load_i is high.
// Ports       : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low reset
//               we_i     - shadow write strobe (already address-decoded)
//               be_i     - byte enables for the write
//               data_i   - write data
//               load_i   - copy shadow into active
//               shadow_o - current shadow value
//               active_o - current active value
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_word #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_WORD   = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    load_i,
    output logic [DATA_WIDTH-1:0]   shadow_o,
    output logic [DATA_WIDTH-1:0]   active_o
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] shadow_d;
    logic [DATA_WIDTH-1:0] active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (we_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    shadow_d[b*8 +: 8] = data_i[b*8 +: 8];
                end
            end
        end
    end

    // Active loads shadow_q, not shadow_d, so a write in the same cycle as
    // a load stays in shadow until the next commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= RST_WORD;
            active_q <= RST_WORD;
        end else begin
            shadow_q <= shadow_d;
            if (load_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;

endmodule : uart_cfg_word
`default_nettype wire

// File: rtl/uart_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg_regs
// Description : UART configuration register bank. DEPTH words, each with a
//               host-visible shadow copy and a live active copy. A commit
//               copies shadow to active only while the UART datapath is
//               idle; a commit raised mid-frame is held pending until idle.
// Ports       : CLKip   - clock, rising edge
//               RSTin   - asynchronous active-low reset
//               WEi     - shadow write strobe
//               RDi     - shadow read strobe
//               ADDRi   - word address
//               DATAi   - write data
//               BEi     - write byte enables
//               COMMITi - request shadow -> active copy
//               IDLEi   - UART datapath idle
//               Qo      - registered read data
//               QVo     - read data valid pulse
//               ERRo    - out-of-range access pulse
//               PENDo   - commit pending
//               CFGo    - packed active copy, word k at [k*W +: W]
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_regs
    import uart_pkg::*;
#(
    parameter int                          DATA_WIDTH = UART_CFG_WIDTH,
    parameter int                          DEPTH      = UART_CFG_DEPTH,
    parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VAL    = '0,
    localparam int                         ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        CLKip,
    input  logic                        RSTin,
    input  logic                        WEi,
    input  logic                        RDi,
    input  logic [ADDR_WIDTH-1:0]       ADDRi,
    input  logic [DATA_WIDTH-1:0]       DATAi,
    input  logic [DATA_WIDTH/8-1:0]     BEi,
    input  logic                        COMMITi,
    input  logic                        IDLEi,
    output logic [DATA_WIDTH-1:0]       Qo,
    output logic                        QVo,
    output logic                        ERRo,
    output logic                        PENDo,
    output logic [DEPTH*DATA_WIDTH-1:0] CFGo
);

    logic                  in_range;
    logic                  apply;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] shadow [DEPTH];
    logic [DATA_WIDTH-1:0] active [DEPTH];

    logic [DATA_WIDTH-1:0] q_q;
    logic                  qv_q;
    logic                  err_q;
    logic                  pend_q;
    logic                  pend_d;

    // Only reachable for non-power-of-2 DEPTH.
    assign in_range = (32'(ADDRi) < 32'(DEPTH));

    // A pending commit fires on the first idle cycle; a fresh request while
    // busy arms the flag. Repeated requests while pending change nothing.
    assign apply  = (COMMITi | pend_q) & IDLEi;
    assign pend_d = (COMMITi | pend_q) & ~IDLEi;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_word
            uart_cfg_word #(
                .DATA_WIDTH (DATA_WIDTH),
                .RST_WORD   (RST_VAL[k*DATA_WIDTH +: DATA_WIDTH])
            ) u_word (
                .clk_i    (CLKip),
                .rst_ni   (RSTin),
                .we_i     (WEi && (ADDRi == ADDR_WIDTH'(k))),
                .be_i     (BEi),
                .data_i   (DATAi),
                .load_i   (apply),
                .shadow_o (shadow[k]),
                .active_o (active[k])
            );

            assign CFGo[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
        end
    endgenerate

    // Read mux over the pre-write shadow, so a same-cycle read/write to one
    // address returns the old value.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (in_range && (ADDRi == ADDR_WIDTH'(k))) begin
                rd_data = shadow[k];
            end
        end
    end

    always_ff @(posedge CLKip or negedge RSTin) begin
        if (!RSTin) begin
            q_q    <= '0;
            qv_q   <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (RDi) begin
                q_q <= rd_data;
            end
            qv_q   <= RDi;
            err_q  <= (RDi | WEi) & ~in_range;
            pend_q <= pend_d;
        end
    end

    assign Qo    = q_q;
    assign QVo   = qv_q;
    assign ERRo  = err_q;
    assign PENDo = pend_q;

endmodule : uart_cfg_regs
`default_nettype wire

// File: tb/tb_uart_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cfg_regs
// Description : Self-checking bench for uart_cfg_regs. Instance A uses
//               DEPTH=4 with word0=434; instance B uses DEPTH=3 to reach an
//               out-of-range address. Read results for A are predicted by a
//               shadow model and queued as each read is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cfg_regs;

    localparam int DW = 32;
    localparam logic [4*DW-1:0] RSTV = {96'd0, 32'd434};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A (DEPTH=4)
    logic          a_we, a_rd, a_commit, a_idle;
    logic [1:0]    a_addr;
    logic [DW-1:0] a_data;
    logic [3:0]    a_be;
    logic [DW-1:0] a_q;
    logic          a_qv, a_err, a_pend;
    logic [4*DW-1:0] a_cfg;

    // Instance B (DEPTH=3)
    logic          b_we, b_rd, b_commit, b_idle;
    logic [1:0]    b_addr;
    logic [DW-1:0] b_data;
    logic [3:0]    b_be;
    logic [DW-1:0] b_q;
    logic          b_qv, b_err, b_pend;
    logic [3*DW-1:0] b_cfg;

    uart_cfg_regs #(.DATA_WIDTH(DW), .DEPTH(4), .RST_VAL(RSTV)) u_dut_a (
        .CLKip(clk), .RSTin(rst_n), .WEi(a_we), .RDi(a_rd), .ADDRi(a_addr),
        .DATAi(a_data), .BEi(a_be), .COMMITi(a_commit), .IDLEi(a_idle),
        .Qo(a_q), .QVo(a_qv), .ERRo(a_err), .PENDo(a_pend), .CFGo(a_cfg)
    );

    uart_cfg_regs #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut_b (
        .CLKip(clk), .RSTin(rst_n), .WEi(b_we), .RDi(b_rd), .ADDRi(b_addr),
        .DATAi(b_data), .BEi(b_be), .COMMITi(b_commit), .IDLEi(b_idle),
        .Qo(b_q), .QVo(b_qv), .ERRo(b_err), .PENDo(b_pend), .CFGo(b_cfg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model of instance A
    logic [DW-1:0] m_shadow [4];
    logic [DW-1:0] m_active [4];
    logic          m_pend;
    logic [DW-1:0] sb_q [$];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_shadow[k] = (k == 0) ? 32'd434 : 32'd0;
            m_active[k] = m_shadow[k];
        end
        m_pend = 1'b0;
        sb_q.delete();
    endtask

    task automatic idle_inputs();
        a_we = 0; a_rd = 0; a_commit = 0; a_idle = 0; a_addr = 0; a_data = 0; a_be = 0;
        b_we = 0; b_rd = 0; b_commit = 0; b_idle = 0; b_addr = 0; b_data = 0; b_be = 0;
    endtask

    // Advance one clock, updating the model from the inputs being applied.
    task automatic tick();
        if (rst_n) begin
            if (a_rd) sb_q.push_back(m_shadow[a_addr]);
            if ((a_commit | m_pend) & a_idle) begin
                for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
            end
            if (a_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) m_shadow[a_addr][b*8 +: 8] = a_data[b*8 +: 8];
            end
            m_pend = (a_commit | m_pend) & ~a_idle;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++; if (a_q !== 32'd0)  begin n_fail++; $display("FAIL reset_q got=%h exp=0", a_q); end
        n_tests++; if (a_qv !== 1'b0)  begin n_fail++; $display("FAIL reset_qv got=%b exp=0", a_qv); end
        n_tests++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", a_err); end
        n_tests++; if (a_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend got=%b exp=0", a_pend); end
        n_tests++; if (a_cfg !== RSTV) begin n_fail++; $display("FAIL reset_cfg got=%h exp=%h", a_cfg, RSTV); end
        n_tests++; if (b_cfg !== '0)   begin n_fail++; $display("FAIL reset_cfg_b got=%h exp=0", b_cfg); end
    endtask

    task automatic test_read_reset_vals();
        logic [DW-1:0] exp;
        logic [DW-1:0] fixed [4];
        fixed[0] = 32'd434; fixed[1] = 0; fixed[2] = 0; fixed[3] = 0;
        for (int a = 0; a < 4; a++) begin
            a_rd = 1; a_addr = 2'(a);
            tick();
            n_tests++;
            if (a_qv !== 1'b1 || sb_q.size() == 0) begin
                n_fail++; $display("FAIL rd_rst_qv addr=%0d got=%b exp=1", a, a_qv);
            end else begin
                exp = sb_q.pop_front();
                if (a_q !== exp || a_q !== fixed[a]) begin
                    n_fail++; $display("FAIL rd_rst_q addr=%0d got=%h exp=%h", a, a_q, fixed[a]);
                end
            end
        end
        a_rd = 0;
        tick();
        n_tests++; if (a_qv !== 1'b0) begin n_fail++; $display("FAIL rd_qv_drop got=%b exp=0", a_qv); end
        n_tests++; if (a_q !== 32'd0) begin n_fail++; $display("FAIL rd_q_hold got=%h exp=0", a_q); end
        n_tests++; if (a_cfg[31:0] !== 32'd434) begin n_fail++; $display("FAIL cfg_w0 got=%h exp=434", a_cfg[31:0]); end
    endtask

    task automatic test_byte_write();
        logic [DW-1:0] exp;
        a_we = 1; a_addr = 2'd1; a_data = 32'hDEADBEEF; a_be = 4'b0101;
        tick();
        a_we = 0; a_rd = 1; a_addr = 2'd1;
        tick();
        a_rd = 0;
        n_tests++;
        if (a_qv !== 1'b1 || sb_q.size() == 0) begin
            n_fail++; $display("FAIL bw_qv got=%b exp=1", a_qv);
        end else begin
            exp = sb_q.pop_front();
            if (a_q !== exp || a_q !== 32'h00AD00EF) begin
                n_fail++; $display("FAIL bw_q got=%h exp=00ad00ef", a_q);
            end
        end
        n_tests++; if (a_cfg[63:32] !== 32'd0) begin n_fail++; $display("FAIL bw_active got=%h exp=0", a_cfg[63:32]); end
    endtask

    task automatic test_pending_commit();
        a_commit = 1; a_idle = 0;
        tick();
        a_commit = 0;
        n_tests++; if (a_pend !== 1'b1) begin n_fail++; $display("FAIL pend_set got=%b exp=1", a_pend); end
        for (int i = 0; i < 4; i++) begin
            a_commit = (i == 2);
            tick();
            n_tests++;
            if (a_pend !== 1'b1 || a_cfg[63:32] !== 32'd0) begin
                n_fail++; $display("FAIL pend_hold cyc=%0d pend=%b w1=%h exp pend=1 w1=0", i, a_pend, a_cfg[63:32]);
            end
        end
        a_commit = 0; a_idle = 1;
        tick();
        a_idle = 0;
        n_tests++; if (a_cfg[63:32] !== 32'h00AD00EF) begin n_fail++; $display("FAIL pend_apply got=%h exp=00ad00ef", a_cfg[63:32]); end
        n_tests++; if (a_pend !== 1'b0) begin n_fail++; $display("FAIL pend_clear got=%b exp=0", a_pend); end
        tick();
        n_tests++; if (a_pend !== 1'b0) begin n_fail++; $display("FAIL pend_stay got=%b exp=0", a_pend); end
    endtask

    task automatic test_write_commit_same();
        a_we = 1; a_addr = 2'd0; a_data = 32'd868; a_be = 4'hF; a_commit = 1; a_idle = 1;
        tick();
        a_we = 0; a_commit = 0; a_idle = 0;
        n_tests++; if (a_cfg[31:0] !== 32'd434) begin n_fail++; $display("FAIL wc_same got=%h exp=434", a_cfg[31:0]); end
        a_commit = 1; a_idle = 1;
        tick();
        a_commit = 0; a_idle = 0;
        n_tests++; if (a_cfg[31:0] !== 32'd868) begin n_fail++; $display("FAIL wc_second got=%h exp=868", a_cfg[31:0]); end
        n_tests++;
        if (a_cfg[63:32] !== 32'h00AD00EF) begin n_fail++; $display("FAIL wc_w1 got=%h exp=00ad00ef", a_cfg[63:32]); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        logic exp_v;
        for (int i = 0; i < 24; i++) begin
            a_we   = 1'($urandom_range(0, 1));
            a_rd   = (i % 3 != 2) ? 1'b1 : 1'($urandom_range(0, 1));
            a_addr = 2'($urandom_range(0, 3));
            a_data = $urandom;
            a_be   = 4'($urandom_range(0, 15));
            tick();
            exp_v = (sb_q.size() != 0);
            n_tests++;
            if (a_qv !== exp_v) begin
                n_fail++; $display("FAIL b2b_qv cyc=%0d got=%b exp=%b", i, a_qv, exp_v);
                sb_q.delete();
            end else if (exp_v) begin
                exp = sb_q.pop_front();
                if (a_q !== exp) begin
                    n_fail++; $display("FAIL b2b_q cyc=%0d got=%h exp=%h", i, a_q, exp);
                end
            end
        end
        a_we = 0; a_rd = 0;
        tick();
        sb_q.delete();
    endtask

    task automatic test_out_of_range();
        b_we = 1; b_addr = 2'd2; b_data = 32'h12345678; b_be = 4'hF;
        tick();
        b_we = 0; b_rd = 1; b_addr = 2'd2;
        tick();
        b_rd = 0;
        n_tests++; if (b_q !== 32'h12345678) begin n_fail++; $display("FAIL oor_pre got=%h exp=12345678", b_q); end
        b_we = 1; b_addr = 2'd3; b_data = 32'hFFFFFFFF; b_be = 4'hF;
        tick();
        b_we = 0;
        n_tests++; if (b_err !== 1'b1 || b_qv !== 1'b0) begin n_fail++; $display("FAIL oor_wr err=%b qv=%b exp err=1 qv=0", b_err, b_qv); end
        tick();
        n_tests++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got=%b exp=0", b_err); end
        b_rd = 1; b_addr = 2'd3;
        tick();
        b_rd = 0;
        n_tests++;
        if (b_q !== 32'd0 || b_qv !== 1'b1 || b_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_rd q=%h qv=%b err=%b exp q=0 qv=1 err=1", b_q, b_qv, b_err);
        end
        for (int a = 0; a < 3; a++) begin
            b_rd = 1; b_addr = 2'(a);
            tick();
            n_tests++;
            if (b_q !== ((a == 2) ? 32'h12345678 : 32'd0) || b_err !== 1'b0) begin
                n_fail++; $display("FAIL oor_shadow addr=%0d got=%h err=%b", a, b_q, b_err);
            end
        end
        b_rd = 0;
        tick();
    endtask

    task automatic test_reset_pending();
        a_we = 1; a_addr = 2'd3; a_data = 32'hA5A5A5A5; a_be = 4'hF;
        tick();
        a_we = 0; a_rd = 1; a_addr = 2'd3; a_commit = 1; a_idle = 0;
        tick();
        a_rd = 0; a_commit = 0;
        n_tests++; if (a_pend !== 1'b1) begin n_fail++; $display("FAIL rp_pend got=%b exp=1", a_pend); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_pend !== 1'b0 || a_q !== 32'd0 || a_cfg !== RSTV) begin
            n_fail++; $display("FAIL rp_async pend=%b q=%h cfg=%h exp pend=0 q=0 cfg=%h", a_pend, a_q, a_cfg, RSTV);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_we = 1; a_addr = 2'd2; a_data = 32'h0BADF00D; a_be = 4'hF;
        tick();
        a_we = 0; a_idle = 1;
        repeat (3) tick();
        a_idle = 0;
        n_tests++; if (a_cfg !== RSTV) begin n_fail++; $display("FAIL rp_no_commit got=%h exp=%h", a_cfg, RSTV); end
        n_tests++; if (a_pend !== 1'b0) begin n_fail++; $display("FAIL rp_pend_after got=%b exp=0", a_pend); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_read_reset_vals();
        test_byte_write();
        test_pending_commit();
        test_write_commit_same();
        test_back_to_back();
        test_out_of_range();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_cfg_regs
`default_nettype wire

// File: doc/uart_cfg_regs.md
# uart_cfg_regs

Parametrised configuration register bank for the UART receiver/transmitter. It holds DEPTH words (baud divisor, frame format, and so on) as a software-visible shadow copy and a live active copy. A commit request copies shadow to active only while the UART datapath reports idle, so reconfiguration never corrupts a frame in flight. It replaces the single-word baud-rate store. It sits between the host write/read port and the UART baud generator and frame logic.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8
- DEPTH, 4: number of configuration words; 1..256
- ADDR_WIDTH, $clog2(DEPTH) (minimum 1): address width; derived, not overridden
- RST_VAL, '0: DEPTH*DATA_WIDTH packed reset values; word k is RST_VAL[k*DATA_WIDTH +: DATA_WIDTH]
- CLKip  input  1  clock, all logic on the rising edge
- RSTin  input  1  asynchronous, active-low reset
- WEi  input  1  write strobe to the shadow copy
- RDi  input  1  read strobe from the shadow copy
- ADDRi  input  ADDR_WIDTH  word address for read/write
- DATAi  input  DATA_WIDTH  write data
- BEi  input  DATA_WIDTH/8  byte enables for the write
- COMMITi  input  1  request to copy shadow to active
- IDLEi  input  1  UART datapath idle (no frame in progress)
- Qo  output  DATA_WIDTH  registered read data
- QVo  output  1  read-data valid, one-cycle pulse
- ERRo  output  1  out-of-range access, one-cycle pulse
- PENDo  output  1  commit requested but not yet applied
- CFGo  output  DEPTH*DATA_WIDTH  active copy, word k at [k*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Reset (RSTin low, asynchronous):
  - shadow and active both take RST_VAL
  - Qo=0, QVo=0, ERRo=0, PENDo=0
- Write: WEi high with ADDRi<DEPTH updates the shadow word. Byte b is written only where BEi[b]=1. Active is untouched.
- Read: RDi high with ADDRi<DEPTH loads Qo with the shadow word and drives QVo=1 on the next cycle. Qo holds its value while RDi is low.
- Out of range (ADDRi>=DEPTH, possible only for non-power-of-2 DEPTH):
  - writes are dropped
  - a read loads Qo=0 with QVo=1
  - ERRo pulses on the next cycle, for both reads and writes
- Commit: define apply = (COMMITi | PENDo) & IDLEi.
  - When apply is true, active takes the shadow copy as it stood before this cycle's write, and PENDo clears.
  - When COMMITi is high and IDLEi is low, PENDo sets.
  - PENDo stays set until IDLEi goes high. Repeated COMMITi while pending has no further effect.
- Simultaneous events:
  - Read and write to the same address: Qo returns the old value.
  - Write and apply in the same cycle: the write lands in shadow only and needs a later commit to reach active.
  - Commit during reset: lost; PENDo=0 after reset.

## Timing
- Read latency is 1 cycle: RDi sampled at edge n gives Qo/QVo valid after edge n.
- Write to shadow is visible to a read issued on the following cycle.
- CFGo changes only at the edge where apply is true. It is registered and glitch-free.
- PENDo, ERRo and QVo are all registered outputs.
- Back-to-back reads and writes are accepted every cycle; there is no stall.

## Structure
- Package uart_pkg: UART_CFG_DEPTH, UART_CFG_WIDTH, and a localparam for each word index (CFG_BAUD_DIV=0, CFG_FRAME=1, …). It also holds the default baud divisor used to build RST_VAL.
- Sub-module uart_cfg_word: one shadow/active word pair with byte-enable write, a commit load and a reset value. It is instantiated DEPTH times in a generate loop. The top level keeps the address decode, read mux, the Qo/QVo/ERRo registers and the PENDo flag.

## Test plan
- Reset with RST_VAL word0=434 and the rest 0, then read addresses 0..3 → Qo=434,0,0,0, each with QVo one cycle after RDi; CFGo word0=434.
- Write addr1=0xDEADBEEF with BEi=4'b0101, then read addr1 → Qo=0x00AD00EF; CFGo word1 still 0.
- COMMITi with IDLEi=0 for 5 cycles, then IDLEi=1 → PENDo=1 from the cycle after COMMITi. At the IDLEi edge CFGo word1=0x00AD00EF and PENDo=0.
- Same cycle: write addr0=868 with COMMITi=1 and IDLEi=1 → CFGo word0 keeps its previous value. A second commit makes word0=868.
- DEPTH=3: write and read at addr3 → shadow unchanged, Qo=0, QVo=1, ERRo pulses one cycle for each access.
- Assert RSTin with PENDo=1 → PENDo=0, Qo=0 and CFGo=RST_VAL immediately. A later IDLEi=1 causes no commit.
